// File: rtl/pmem_arb_pkg.sv
// rtl/pmem_arb_pkg.sv - shared types and constants for the physical memory port arbiter
package pmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  typedef enum logic {
    OWN_IFU,
    OWN_LSU
  } owner_e;

  localparam int LAT_MAX = 15;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MASK_W  = 8;

endpackage

// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - single-port memory arbiter between IFU fetches and LSU loads/stores
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int LAT = 1,
  parameter int RR  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask
);

  localparam int CNT_W = $clog2(LAT_MAX + 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic [DATA_W-1:0] resp_q, resp_d;

  logic grant_ifu, grant_lsu, is_store;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_IFU;
      last_q  <= OWN_LSU;
      cnt_q   <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      resp_q  <= resp_d;
    end
  end

  assign ifu_rdata = resp_q;
  assign lsu_rdata = resp_q;

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_d         = last_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    wen_d          = wen_q;
    wdata_d        = wdata_q;
    wmask_d        = wmask_q;
    resp_d         = resp_q;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    mem_valid      = 1'b0;
    mem_raddr      = '0;
    mem_wen        = 1'b0;
    mem_waddr      = '0;
    mem_wdata      = '0;
    mem_wmask      = '0;

    // On a tie the LSU wins unless round-robin says the IFU is owed a turn.
    grant_lsu = lsu_req_valid && (!ifu_req_valid || (RR == 0) || (last_q == OWN_IFU));
    grant_ifu = ifu_req_valid && !grant_lsu;
    is_store  = (owner_q == OWN_LSU) && wen_q;

    unique case (state_q)
      IDLE: begin
        ifu_req_ready = grant_ifu && rst_n;
        lsu_req_ready = grant_lsu && rst_n;
        if (grant_ifu || grant_lsu) begin
          owner_d = grant_lsu ? OWN_LSU : OWN_IFU;
          addr_d  = grant_lsu ? lsu_addr : ifu_addr;
          wen_d   = grant_lsu && lsu_wen;
          wdata_d = grant_lsu ? lsu_wdata : '0;
          wmask_d = grant_lsu ? lsu_wmask : '0;
          cnt_d   = CNT_W'(LAT - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_valid = 1'b1;
        mem_raddr = addr_q;
        if (is_store) begin
          mem_waddr = addr_q;
          mem_wdata = wdata_q;
          mem_wmask = wmask_q;
        end
        // Write strobe only on the final window cycle so a store lands exactly once.
        mem_wen = is_store && (cnt_q == '0);
        if (cnt_q == '0) begin
          resp_d  = is_store ? '0 : mem_rdata;
          last_d  = owner_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        ifu_resp_valid = (owner_q == OWN_IFU);
        lsu_resp_valid = (owner_q == OWN_LSU);
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
